rx_frame_ctrl: RTL and testbench

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

---
 rtl/rx_pkg.sv | 23 ++
 rtl/sat_counter8.sv | 16 +
 rtl/rx_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rx_frame_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receive frame controller: FSM encoding and frame
// framing constants used by the datapath and its statistics.
package rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RECV,
        DISCARD,
        HOLD
    } rx_state_t;

    localparam logic [7:0] BCAST_ADDR    = 8'hFF;
    localparam int         FCS_LEN       = 2;
    localparam int         MIN_FRAME_LEN = 6;

    function automatic logic addr_match(input logic [7:0] dest,
                                        input logic [7:0] station,
                                        input logic       promisc);
        return promisc || (dest == station) || (dest == BCAST_ADDR);
    endfunction

endpackage

// File: rtl/sat_counter8.sv
// Eight-bit statistics counter that sticks at 8'hFF instead of wrapping.
module sat_counter8 (
    input  logic       netclk,
    input  logic       reset,
    input  logic       inc,
    output logic [7:0] value
);

    always_ff @(posedge netclk or posedge reset) begin
        if (reset)
            value <= 8'h00;
        else if (inc && (value != 8'hFF))
            value <= value + 8'd1;
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: filters deframed bytes by destination, writes the
// accepted frame into a linear buffer and holds it until the host releases it.
module rx_frame_ctrl
    import rx_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              netclk,
    input  logic              reset,
    input  logic              byte_ready,
    input  logic [7:0]        din,
    input  logic              frame_complete,
    input  logic              frame_valid,
    input  logic              frame_abort,
    input  logic [7:0]        station_id,
    input  logic              promisc,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              rx_avail,
    output logic [ADDR_W:0]   rx_len,
    input  logic              rx_ack,
    output logic [7:0]        crc_err_cnt,
    output logic [7:0]        abort_cnt,
    output logic [7:0]        drop_cnt,
    output logic [7:0]        ovf_cnt
);

    localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] MIN_LEN  = (ADDR_W+1)'(MIN_FRAME_LEN);
    localparam logic [ADDR_W:0] FCS_SUB  = (ADDR_W+1)'(FCS_LEN);

    rx_state_t         state, state_next;
    logic              byte_q, complete_q, abort_q;
    logic              byte_ev, complete_ev, abort_ev;
    logic [ADDR_W:0]   wr_ptr, wr_ptr_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en, hold_set, hold_clr;
    logic [ADDR_W:0]   hold_len;
    logic              inc_crc, inc_abort, inc_drop, inc_ovf;

    assign byte_ev     = byte_ready && !byte_q;
    assign complete_ev = frame_complete && !complete_q;
    assign abort_ev    = frame_abort && !abort_q;

    always_ff @(posedge netclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A byte arriving together with the closing flag is counted before the length test.
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        wr_addr     = wr_ptr[ADDR_W-1:0];
        wr_en       = 1'b0;
        hold_set    = 1'b0;
        hold_clr    = 1'b0;
        hold_len    = rx_len;
        inc_crc     = 1'b0;
        inc_abort   = 1'b0;
        inc_drop    = 1'b0;
        inc_ovf     = 1'b0;
        case (state)
            IDLE: begin
                wr_addr = '0;
                if (byte_ev) begin
                    if (addr_match(din, station_id, promisc)) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = PTR_ONE;
                        state_next  = RECV;
                    end else begin
                        state_next  = DISCARD;
                    end
                end
            end
            ADDR, RECV: begin
                if (abort_ev) begin
                    inc_abort  = 1'b1;
                    state_next = IDLE;
                end else begin
                    if (byte_ev) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr + PTR_ONE;
                    end
                    if (byte_ev && (wr_ptr == LAST_PTR)) begin
                        inc_ovf    = 1'b1;
                        state_next = DISCARD;
                    end else if (complete_ev) begin
                        if (!frame_valid) begin
                            inc_crc    = 1'b1;
                            state_next = IDLE;
                        end else if (wr_ptr_next < MIN_LEN) begin
                            inc_drop   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            hold_set   = 1'b1;
                            hold_len   = wr_ptr_next - FCS_SUB;
                            state_next = HOLD;
                        end
                    end
                end
            end
            DISCARD: begin
                if (complete_ev || abort_ev)
                    state_next = IDLE;
            end
            HOLD: begin
                if (complete_ev)
                    inc_drop = 1'b1;
                if (rx_ack) begin
                    hold_clr   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == IDLE)
            wr_ptr_next = '0;
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            byte_q     <= 1'b0;
            complete_q <= 1'b0;
            abort_q    <= 1'b0;
            wr_ptr     <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= 8'h00;
            rx_avail   <= 1'b0;
            rx_len     <= '0;
        end else begin
            byte_q     <= byte_ready;
            complete_q <= frame_complete;
            abort_q    <= frame_abort;
            wr_ptr     <= wr_ptr_next;
            buf_we     <= wr_en;
            if (wr_en) begin
                buf_addr  <= wr_addr;
                buf_wdata <= din;
            end
            if (hold_set) begin
                rx_avail <= 1'b1;
                rx_len   <= hold_len;
            end else if (hold_clr) begin
                rx_avail <= 1'b0;
            end
        end
    end

    sat_counter8 u_crc_cnt   (.netclk(netclk), .reset(reset), .inc(inc_crc),   .value(crc_err_cnt));
    sat_counter8 u_abort_cnt (.netclk(netclk), .reset(reset), .inc(inc_abort), .value(abort_cnt));
    sat_counter8 u_drop_cnt  (.netclk(netclk), .reset(reset), .inc(inc_drop),  .value(drop_cnt));
    sat_counter8 u_ovf_cnt   (.netclk(netclk), .reset(reset), .inc(inc_ovf),   .value(ovf_cnt));

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl with a 16-byte buffer: expected buffer
// writes are queued by the stimulus and consumed by an independent monitor.
module tb_rx_frame_ctrl;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              netclk = 1'b0;
    logic              reset;
    logic              byte_ready;
    logic [7:0]        din;
    logic              frame_complete;
    logic              frame_valid;
    logic              frame_abort;
    logic [7:0]        station_id;
    logic              promisc;
    logic              buf_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_wdata;
    logic              rx_avail;
    logic [ADDR_W:0]   rx_len;
    logic              rx_ack;
    logic [7:0]        crc_err_cnt, abort_cnt, drop_cnt, ovf_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  frame[32];
    logic [7:0]  std_bytes[8];

    always #5 netclk = ~netclk;

    rx_frame_ctrl #(.ADDR_W(ADDR_W)) dut (
        .netclk(netclk), .reset(reset), .byte_ready(byte_ready), .din(din),
        .frame_complete(frame_complete), .frame_valid(frame_valid),
        .frame_abort(frame_abort), .station_id(station_id), .promisc(promisc),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .rx_avail(rx_avail), .rx_len(rx_len), .rx_ack(rx_ack),
        .crc_err_cnt(crc_err_cnt), .abort_cnt(abort_cnt),
        .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    // Every buffer write must match the oldest queued expectation.
    always @(negedge netclk) begin
        logic [11:0] exp;
        if (buf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h required no write",
                         buf_addr, buf_wdata);
            end else begin
                exp = exp_q.pop_front();
                check_output("write_addr", int'(buf_addr), int'(exp[11:8]));
                check_output("write_data", int'(buf_wdata), int'(exp[7:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge netclk);
        #2;
    endtask

    task automatic load_frame(input logic [7:0] dest, input int n);
        for (int i = 0; i < n; i++)
            frame[i] = (i < 8) ? std_bytes[i] : 8'(8'h40 + i);
        frame[0] = dest;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_ready = 1'b1;
        din        = b;
        tick(2);
        byte_ready = 1'b0;
        tick(1);
    endtask

    task automatic apply_stimulus(input int n, input bit accepted);
        for (int i = 0; i < n; i++) begin
            if (accepted && i < DEPTH)
                exp_q.push_back({4'(i), frame[i]});
            send_byte(frame[i]);
        end
    endtask

    task automatic complete_frame(input logic valid);
        frame_valid    = valid;
        frame_complete = 1'b1;
        tick(2);
        frame_complete = 1'b0;
        tick(1);
    endtask

    task automatic byte_with_complete(input logic [3:0] addr, input logic [7:0] b);
        exp_q.push_back({addr, b});
        byte_ready     = 1'b1;
        din            = b;
        frame_valid    = 1'b1;
        frame_complete = 1'b1;
        tick(2);
        byte_ready     = 1'b0;
        frame_complete = 1'b0;
        tick(1);
    endtask

    task automatic abort_pulse();
        frame_abort = 1'b1;
        tick(2);
        frame_abort = 1'b0;
        tick(1);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    task automatic check_rx(input string tag, input int avail, input int len);
        check_output({tag, "_rx_avail"}, int'(rx_avail), avail);
        check_output({tag, "_rx_len"}, int'(rx_len), len);
        check_output({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    task automatic check_counters(input string tag, input int crc, input int abt,
                                  input int drop, input int ovf);
        check_output({tag, "_crc_err_cnt"}, int'(crc_err_cnt), crc);
        check_output({tag, "_abort_cnt"}, int'(abort_cnt), abt);
        check_output({tag, "_drop_cnt"}, int'(drop_cnt), drop);
        check_output({tag, "_ovf_cnt"}, int'(ovf_cnt), ovf);
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_buf_we"}, int'(buf_we), 0);
        check_output({tag, "_buf_addr"}, int'(buf_addr), 0);
        check_output({tag, "_buf_wdata"}, int'(buf_wdata), 0);
        check_output({tag, "_rx_avail"}, int'(rx_avail), 0);
        check_output({tag, "_rx_len"}, int'(rx_len), 0);
        check_counters(tag, 0, 0, 0, 0);
    endtask

    initial begin
        std_bytes = '{8'h05, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hC1, 8'hC2};
        reset          = 1'b1;
        byte_ready     = 1'b0;
        din            = 8'h00;
        frame_complete = 1'b0;
        frame_valid    = 1'b0;
        frame_abort    = 1'b0;
        station_id     = 8'h05;
        promisc        = 1'b0;
        rx_ack         = 1'b0;
        tick(2);
        check_reset_state("reset");
        reset = 1'b0;
        tick(1);

        load_frame(8'h05, 8);
        apply_stimulus(8, 1'b1);
        complete_frame(1'b1);
        check_rx("good", 1, 6);
        check_counters("good", 0, 0, 0, 0);

        // Frame arriving while the buffer is held is dropped untouched.
        apply_stimulus(8, 1'b0);
        complete_frame(1'b1);
        check_rx("hold_drop", 1, 6);
        check_counters("hold_drop", 0, 0, 1, 0);
        ack();
        check_output("after_ack_rx_avail", int'(rx_avail), 0);
        ack();
        check_output("idle_ack_rx_avail", int'(rx_avail), 0);

        load_frame(8'h07, 8);
        apply_stimulus(8, 1'b0);
        complete_frame(1'b1);
        check_output("foreign_rx_avail", int'(rx_avail), 0);
        check_output("foreign_pending", exp_q.size(), 0);
        check_counters("foreign", 0, 0, 1, 0);
        promisc = 1'b1;
        apply_stimulus(8, 1'b1);
        complete_frame(1'b1);
        check_rx("promisc", 1, 6);
        ack();
        promisc = 1'b0;

        load_frame(8'hFF, 7);
        apply_stimulus(7, 1'b1);
        complete_frame(1'b1);
        check_rx("bcast", 1, 5);
        ack();

        load_frame(8'h05, 8);
        apply_stimulus(8, 1'b1);
        complete_frame(1'b0);
        check_output("crc_rx_avail", int'(rx_avail), 0);
        check_counters("crc", 1, 0, 1, 0);

        apply_stimulus(3, 1'b1);
        abort_pulse();
        check_output("abort_rx_avail", int'(rx_avail), 0);
        check_counters("abort", 1, 1, 1, 0);

        // Five bytes is one short of the minimum; six is the smallest accepted.
        apply_stimulus(5, 1'b1);
        complete_frame(1'b1);
        check_output("short_rx_avail", int'(rx_avail), 0);
        check_counters("short", 1, 1, 2, 0);
        apply_stimulus(6, 1'b1);
        complete_frame(1'b1);
        check_rx("min", 1, 4);
        ack();

        load_frame(8'h05, 20);
        apply_stimulus(20, 1'b1);
        complete_frame(1'b1);
        check_output("ovf_rx_avail", int'(rx_avail), 0);
        check_output("ovf_pending", exp_q.size(), 0);
        check_counters("ovf", 1, 1, 2, 1);
        load_frame(8'h05, 8);
        apply_stimulus(8, 1'b1);
        complete_frame(1'b1);
        check_rx("after_ovf", 1, 6);
        ack();

        apply_stimulus(5, 1'b1);
        byte_with_complete(4'd5, frame[5]);
        check_rx("same_cycle", 1, 4);
        check_counters("same_cycle", 1, 1, 2, 1);

        reset = 1'b1;
        tick(1);
        check_reset_state("hold_reset");
        reset = 1'b0;
        tick(1);
        apply_stimulus(8, 1'b1);
        complete_frame(1'b1);
        check_rx("post_reset", 1, 6);
        ack();

        for (int k = 0; k < 300; k++) begin
            apply_stimulus(1, 1'b1);
            complete_frame(1'b0);
        end
        check_counters("saturate", 255, 0, 0, 0);
        check_output("final_pending", exp_q.size(), 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
